keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans the 4x4 Pmod keypad used by player B and produces the 4-bit key code on
//  playerB that drives chara_control (2=up, 8=down, 4=left, 6=right, 5=bomb).
//  Drives the columns in turn, samples the rows, debounces over whole scan frames
//  and holds a clean code for the game logic.
// PARAMETERS
//  SCAN_CYCLES     16'd50000  clk cycles each column is held active (min 4)
//  DEBOUNCE_SCANS  8'd4       consecutive identical frames required to commit (min 1)
// PORTS
//  clk        in   1  system clock, the same clk as chara_control
//  rst        in   1  synchronous, active-high reset
//  col        out  4  column drive, active low, exactly one bit low at any time
//  row        in   4  row sense, active low (pulled up), asynchronous to clk
//  playerB    out  4  committed key code; 4'h0 when no key is held
//  key_valid  out  1  1 while a debounced key is held
//  key_press  out  1  one-cycle pulse on each new committed key, including a change of key
// BEHAVIOUR
//  - Reset: col=4'b1110, playerB=0, key_valid=0, key_press=0. All counters, the
//    candidate and the synchroniser are cleared. Reset mid-frame abandons the frame.
//  - row passes through a 2-flop synchroniser (row_s) before any use.
//  - Column counter runs 0..SCAN_CYCLES-1. col_idx advances 0->1->2->3->0 on wrap.
//    col = ~(4'b0001 << col_idx).
//  - row_s is sampled only on the last cycle of each column window, which covers
//    synchroniser latency and settling. Four windows make one frame of
//    4*SCAN_CYCLES cycles.
//  - Key map [row][col], with row[0] the top row and col[0] the left column:
//      r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
//  - Multiple keys: the first low row found in scan order wins. Scan order is
//    col_idx 0..3, then row 0..3 within each column. Example: 2 and 8 held -> 2.
//  - End of frame gives a 5-bit observation obs = {hit, code}. When hit=0, code=0.
//  - Debounce:
//      if obs == cand: stable_cnt++, saturating at DEBOUNCE_SCANS
//      else:           cand <= obs, stable_cnt <= 1
//    Commit when stable_cnt reaches DEBOUNCE_SCANS and cand != the committed value.
//  - Commit: on the clock after the final frame sample, playerB <= cand.code and
//    key_valid <= cand.hit. key_press = 1 for that single cycle when cand.hit=1.
//  - Commit latency from a clean press: at most (DEBOUNCE_SCANS+1) frames + 3 clk.
//  - Release is debounced in the same way: DEBOUNCE_SCANS idle frames -> playerB=0,
//    key_valid=0, no key_press.
//  - Key '0' commits playerB=0 with key_valid=1. chara_control ignores it.
//  - A direct change from one key to another commits the new code with a fresh
//    key_press. There is no forced idle in between.
//  - Outputs are registered. col has no combinational path from row.
// CONFIGURATION
//  KEYPAD_ONESHOT_EN
//   - Defined: playerB shows the committed code for exactly one clk (the key_press
//     cycle) and is 4'h0 otherwise, giving one move per press. key_valid still
//     tracks the held state.
//   - Undefined (default): playerB holds the code for as long as key_valid=1.
// TESTING
//  All tests use SCAN_CYCLES=4 and DEBOUNCE_SCANS=2, so one frame = 16 clk.
//  1. rst for 3 clk -> col=4'b1110, playerB=0, key_valid=0. col walks
//     1110->1101->1011->0111, 4 clk each, and repeats.
//  2. Hold key 5 (row[1] low only while col[1] low) -> within 3 frames + 3 clk:
//     playerB=4'h5, key_valid=1, key_press high for exactly 1 clk.
//     Release -> playerB=0 and key_valid=0 after 2-3 frames.
//  3. Bounce: key 8 present for 1 frame, absent for 1, present for 1 ->
//     no commit, playerB stays 0. Then hold steady -> playerB=4'h8.
//  4. Hold 2 and 8 together -> playerB=4'h2. Drop 2 while 8 stays held ->
//     playerB=4'h8 with a second key_press and key_valid held at 1 throughout.
//  5. Assert rst mid-frame while 6 is committed -> next clk playerB=0,
//     key_valid=0, col=1110. With 6 still held, playerB re-commits 4'h6.
//  6. With KEYPAD_ONESHOT_EN defined, hold 4 for 10 frames -> playerB=4'h4 for
//     exactly 1 clk, coincident with key_press; key_valid=1 for the whole hold.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Pmod keypad pins plus the debounced key-code outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] playerB;
    logic       key_valid;
    logic       key_press;

    modport master (
        output col,
        output playerB,
        output key_valid,
        output key_press,
        input  row
    );

    modport slave (
        input  col,
        input  playerB,
        input  key_valid,
        input  key_press,
        output row
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 keypad column scanner with frame-level debounce that
//                drives the player B key code. Optional macro
//                KEYPAD_ONESHOT_EN makes playerB a one-cycle pulse per press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter logic [15:0] SCAN_CYCLES    = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    keypad_scanner_if.master  kp
);

    logic [3:0]  row_meta_q, row_meta_d;
    logic [3:0]  row_s_q,    row_s_d;
    logic [15:0] cyc_q,      cyc_d;
    logic [1:0]  col_idx_q,  col_idx_d;
    logic [3:0]  col_q,      col_d;
    logic        acc_hit_q,  acc_hit_d;
    logic [3:0]  acc_code_q, acc_code_d;
    logic [4:0]  cand_q,     cand_d;
    logic [7:0]  stable_cnt_q, stable_cnt_d;
    logic [4:0]  commit_q,   commit_d;
    logic [3:0]  player_b_q, player_b_d;
    logic        key_press_q, key_press_d;

    logic        win_end;
    logic        row_found;
    logic [1:0]  row_first;
    logic        obs_hit;
    logic [3:0]  obs_code;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign win_end = (cyc_q == SCAN_CYCLES - 16'd1);

    always_comb begin
        row_meta_d   = kp.row;
        row_s_d      = row_meta_q;
        cyc_d        = cyc_q + 16'd1;
        col_idx_d    = col_idx_q;
        col_d        = col_q;
        acc_hit_d    = acc_hit_q;
        acc_code_d   = acc_code_q;
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        commit_d     = commit_q;
        key_press_d  = 1'b0;
`ifdef KEYPAD_ONESHOT_EN
        player_b_d   = 4'h0;
`else
        player_b_d   = player_b_q;
`endif

        // Descending loop leaves the lowest-numbered low row as the winner.
        row_found = 1'b0;
        row_first = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s_q[r]) begin
                row_found = 1'b1;
                row_first = 2'(r);
            end
        end

        // An earlier column's hit always outranks the current column.
        obs_hit  = acc_hit_q | row_found;
        obs_code = acc_hit_q ? acc_code_q :
                   (row_found ? key_code(row_first, col_idx_q) : 4'h0);

        if (win_end) begin
            cyc_d     = 16'd0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(4'b0001 << col_idx_d);
            if (col_idx_q == 2'd3) begin
                acc_hit_d  = 1'b0;
                acc_code_d = 4'h0;
                if ({obs_hit, obs_code} == cand_q) begin
                    if (stable_cnt_q < DEBOUNCE_SCANS)
                        stable_cnt_d = stable_cnt_q + 8'd1;
                end else begin
                    cand_d       = {obs_hit, obs_code};
                    stable_cnt_d = 8'd1;
                end
            end else begin
                acc_hit_d  = obs_hit;
                acc_code_d = obs_code;
            end
        end

        if ((stable_cnt_q == DEBOUNCE_SCANS) && (cand_q != commit_q)) begin
            commit_d    = cand_q;
            player_b_d  = cand_q[3:0];
            key_press_d = cand_q[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser clears to the idle (pulled-up) row level.
            row_meta_q   <= 4'hF;
            row_s_q      <= 4'hF;
            cyc_q        <= 16'd0;
            col_idx_q    <= 2'd0;
            col_q        <= 4'b1110;
            acc_hit_q    <= 1'b0;
            acc_code_q   <= 4'h0;
            cand_q       <= 5'd0;
            stable_cnt_q <= 8'd0;
            commit_q     <= 5'd0;
            player_b_q   <= 4'h0;
            key_press_q  <= 1'b0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_s_q      <= row_s_d;
            cyc_q        <= cyc_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            acc_hit_q    <= acc_hit_d;
            acc_code_q   <= acc_code_d;
            cand_q       <= cand_d;
            stable_cnt_q <= stable_cnt_d;
            commit_q     <= commit_d;
            player_b_q   <= player_b_d;
            key_press_q  <= key_press_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.playerB   = player_b_q;
    assign kp.key_valid = commit_q[4];
    assign kp.key_press = key_press_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Keypad model, frame-level reference model and checks for
//                keypad_scanner (SCAN_CYCLES=4, DEBOUNCE_SCANS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SC    = 4;
    localparam int DB    = 2;
    localparam int FRAME = 4 * SC;
`ifdef KEYPAD_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    // Key bit index = row*4 + col
    localparam int K2 = 1;
    localparam int K4 = 4;
    localparam int K5 = 5;
    localparam int K6 = 6;
    localparam int K8 = 9;

    localparam logic [3:0] KMAP [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'h0, 4'hF, 4'hE, 4'hD};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_CYCLES    (16'd4),
        .DEBOUNCE_SCANS (8'd2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    function automatic logic [3:0] row_of(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = ~|(k[i*4 +: 4] & ~c);
        return r;
    endfunction

    assign kif.row = row_of(keys, kif.col);

    function automatic logic [4:0] frame_obs(input logic [15:0] k);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (k[r*4 + c]) return {1'b1, KMAP[r*4 + c]};
        return 5'd0;
    endfunction

    // Reference model: frame counter, history of the last DB observations.
    int         mdl_n = 0;
    logic [4:0] hist [$];
    logic [4:0] m_commit = 5'd0;
    logic [4:0] m_cand   = 5'd0;
    bit         m_pending = 1'b0;
    logic [3:0] m_pb  = 4'h0;
    logic       m_kv  = 1'b0;
    logic       m_kp  = 1'b0;
    logic [3:0] m_col = 4'b1110;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mdl_n     = 0;
            hist.delete();
            m_commit  = 5'd0;
            m_pending = 1'b0;
            m_pb      = 4'h0;
            m_kv      = 1'b0;
            m_kp      = 1'b0;
            m_live    = 1'b1;
        end else begin
            m_kp = 1'b0;
            if (ONESHOT) m_pb = 4'h0;
            if (m_pending) begin
                m_commit  = m_cand;
                m_kv      = m_cand[4];
                m_kp      = m_cand[4];
                m_pb      = m_cand[3:0];
                m_pending = 1'b0;
            end
            if (mdl_n % FRAME == FRAME - 1) begin
                bit same;
                hist.push_back(frame_obs(keys));
                if (hist.size() > DB) void'(hist.pop_front());
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
                if (hist.size() == DB && same && hist[0] != m_commit) begin
                    m_pending = 1'b1;
                    m_cand    = hist[0];
                end
            end
            mdl_n++;
        end
        m_col = ~(4'b0001 << 2'((mdl_n / SC) % 4));
    end

    always @(negedge clk) begin
        if (m_live) begin
            vectors++;
            if (kif.col !== m_col || kif.playerB !== m_pb ||
                kif.key_valid !== m_kv || kif.key_press !== m_kp) begin
                miscompares++;
                $display("FAIL cycle t=%0t col=%b/%b playerB=%h/%h key_valid=%b/%b key_press=%b/%b (got/exp)",
                         $time, kif.col, m_col, kif.playerB, m_pb,
                         kif.key_valid, m_kv, kif.key_press, m_kp);
            end
        end
    end

    int press_cnt = 0;
    bit watch_kv  = 1'b0;
    bit kv_dropped = 1'b0;
    always @(negedge clk) begin
        if (kif.key_press) press_cnt++;
        if (watch_kv && !kif.key_valid) kv_dropped = 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic next_boundary();
        do begin
            @(posedge clk);
            #1;
        end while (mdl_n % FRAME != 0);
    endtask

    // Returns number of edges until key_press is seen, or -1 on timeout.
    task automatic wait_press(input int bound, output int lat);
        lat = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (kif.key_press) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_kv_low(input int bound, output int lat);
        lat = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!kif.key_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] col_tab [0:3];
        int lat;
        int p0;
        int pb4, kv1, coin;
        col_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset values and column walk
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset col", int'(kif.col), int'(4'b1110));
        chk("reset playerB", int'(kif.playerB), 0);
        chk("reset key_valid", int'(kif.key_valid), 0);
        chk("reset key_press", int'(kif.key_press), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("col walk", int'(kif.col), int'(col_tab[(k / SC) % 4]));
        end
        next_boundary();

        // Clean press and release of key 5
        keys = 16'h0; keys[K5] = 1'b1;
        wait_press(3 * FRAME + 4, lat);
        chk("key5 press latency", lat, 2 * FRAME + 1);
        chk("key5 playerB", int'(kif.playerB), 5);
        chk("key5 key_valid", int'(kif.key_valid), 1);
        @(negedge clk);
        chk("key5 press width", int'(kif.key_press), 0);
        next_boundary();
        next_boundary();
        chk("key5 held playerB", int'(kif.playerB), ONESHOT ? 0 : 5);
        keys = 16'h0;
        wait_kv_low(3 * FRAME + 4, lat);
        chk("key5 release latency", lat, 2 * FRAME + 1);
        chk("key5 release playerB", int'(kif.playerB), 0);
        next_boundary();

        // Bounce on key 8 must not commit
        p0 = press_cnt;
        keys = 16'h0; keys[K8] = 1'b1;
        next_boundary();
        keys = 16'h0;
        next_boundary();
        keys[K8] = 1'b1;
        next_boundary();
        @(posedge clk);
        @(negedge clk);
        chk("bounce playerB", int'(kif.playerB), 0);
        chk("bounce key_valid", int'(kif.key_valid), 0);
        chk("bounce no press", press_cnt, p0);
        wait_press(2 * FRAME, lat);
        chk("key8 steady press seen", int'(lat >= 0), 1);
        chk("key8 playerB", int'(kif.playerB), 8);
        next_boundary();

        // 2 and 8 together, then drop 2
        keys = 16'h0; keys[K2] = 1'b1; keys[K8] = 1'b1;
        wait_press(3 * FRAME + 4, lat);
        chk("2+8 playerB", int'(kif.playerB), 2);
        next_boundary();
        p0 = press_cnt;
        kv_dropped = 1'b0;
        watch_kv = 1'b1;
        keys[K2] = 1'b0;
        wait_press(3 * FRAME + 4, lat);
        chk("drop2 playerB", int'(kif.playerB), 8);
        next_boundary();
        watch_kv = 1'b0;
        chk("drop2 key_valid held", int'(kv_dropped), 0);
        chk("drop2 second press", press_cnt, p0 + 1);

        // Mid-frame reset with key 6 committed
        keys = 16'h0; keys[K6] = 1'b1;
        wait_press(3 * FRAME + 4, lat);
        chk("key6 playerB", int'(kif.playerB), 6);
        next_boundary();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset playerB", int'(kif.playerB), 0);
        chk("midreset key_valid", int'(kif.key_valid), 0);
        chk("midreset col", int'(kif.col), int'(4'b1110));
        @(posedge clk);
        #1 rst = 1'b0;
        wait_press(3 * FRAME + 4, lat);
        chk("key6 recommit latency", lat, 2 * FRAME + 1);
        chk("key6 recommit playerB", int'(kif.playerB), 6);
        next_boundary();

        // Long hold of key 4 from idle
        keys = 16'h0;
        wait_kv_low(3 * FRAME + 4, lat);
        next_boundary();
        keys[K4] = 1'b1;
        pb4 = 0; kv1 = 0; coin = 0;
        for (int k = 0; k < 10 * FRAME; k++) begin
            @(negedge clk);
            if (kif.playerB == 4'h4) pb4++;
            if (kif.key_valid) kv1++;
            if (kif.playerB == 4'h4 && kif.key_press) coin++;
        end
        chk("key4 playerB cycles", pb4, ONESHOT ? 1 : 10 * FRAME - (2 * FRAME + 1));
        chk("key4 key_valid cycles", kv1, 10 * FRAME - (2 * FRAME + 1));
        chk("key4 press coincident", coin, 1);
        next_boundary();

        // Randomised key sequences checked by the model every cycle
        for (int s = 0; s < 80; s++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            keys = 16'h0;
            if (sel >= 3) keys[$urandom_range(0, 15)] = 1'b1;
            if (sel >= 8) keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(1, 14)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            repeat ($urandom_range(1, 4)) next_boundary();
        end
        keys = 16'h0;
        repeat (3) next_boundary();

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
